bsg_link_core_arbiter: RTL
==========================

Name: bsg_link_core_arbiter

Overview:
- Round-robin, packet-locking arbiter that shares one core-side link transmit port among num_req_p requesters.
- Sits in core_clk_i domain directly in front of the upstream DDR link's core_data_i/core_valid_i/core_ready_o interface.
- Guarantees packets are never interleaved on the link.
- Stamps the source index into each header flit so the far side can demultiplex.

Parameters:
num_req_p, 4, number of requesters (2..8)
width_p, 64, flit width; matches link core data width
len_width_p, 4, header length field width; payload flits per packet = header[len_width_p-1:0]
lg_num_req_lp, $clog2(num_req_p), local; source tag width

Ports:
core_clk_i  in  1  core clock; all logic on rising edge
core_reset_n_i  in  1  synchronous, active-low reset
req_data_i  in  num_req_p*width_p  flattened requester flits, requester i at [i*width_p +: width_p]
req_valid_i  in  num_req_p  requester flit valid
req_ready_o  out  num_req_p  requester flit accepted when req_valid_i[i] & req_ready_o[i]
link_data_o  out  width_p  flit to link core side
link_valid_o  out  1  flit valid to link
link_ready_i  in  1  link core-side ready; transfer = link_valid_o & link_ready_i
grant_o  out  lg_num_req_lp  index of currently selected requester (debug)
busy_o  out  1  1 while in state BODY

Behaviour:
- Zero-latency combinational datapath.
  - link_valid_o = req_valid_i[grant].
  - req_ready_o[grant] = link_ready_i; all other req_ready_o bits are 0.
  - No flit storage in the block.
- Header flit: link_data_o = selected flit with bits [width_p-1 -: lg_num_req_lp] replaced by grant. Body flits pass unmodified.
- State machine, states IDLE and BODY.
- IDLE:
  - grant = first requester with req_valid_i set, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., num_req_p-1, 0, ...).
  - If no requester is valid: grant = rr_ptr and link_valid_o = 0.
  - On a header transfer with len = header[len_width_p-1:0]:
    - len==0: stay IDLE; rr_ptr <= grant+1 mod num_req_p.
    - len>0: lock grant into grant_r; cnt_r <= len; go to BODY.
- BODY:
  - grant = grant_r; other requesters are ignored even if valid.
  - Each transfer decrements cnt_r.
  - Transfer with cnt_r==1: go to IDLE; rr_ptr <= grant_r+1 mod num_req_p.
  - Requester valid low mid-packet: hold state, cnt_r unchanged, link_valid_o = 0.
- link_ready_i low: no state change, all req_ready_o 0, link_data_o/link_valid_o still driven.
- Fairness: each valid requester waits at most num_req_p-1 packets before being granted.
- Requesters must not drop req_valid_i or change data while valid and not ready. The arbiter's grant in IDLE can still change between cycles if a higher-priority requester asserts; this is legal because the link has not yet accepted.
- Reset (core_reset_n_i==0 at clock edge):
  - state=IDLE, rr_ptr=0, grant_r=0, cnt_r=0.
  - Outputs while in reset: req_ready_o=0, link_valid_o=0, busy_o=0, grant_o=0.
  - Reset mid-packet abandons the packet without a flush; link and requesters are reset together by system convention.
- cnt_r is len_width_p bits wide; max packet = 1 header + 2^len_width_p-1 body flits.

Optional Feature:
- Macro BSG_LINK_ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_flits_o, num_req_p*32 bits: one saturating 32-bit counter per requester.
  - Counter i increments on every link transfer whose grant==i (header and body).
  - Counters hold at 32'hFFFF_FFFF, clear on reset.
- When undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset held 3 cycles with all req_valid_i=1 -> link_valid_o=0, req_ready_o=0; first cycle after release grant_o=0.
2. Req0 header len=3 plus 3 body flits, req1 valid throughout, link_ready_i=1 -> link sees req0 H,B,B,B then req1 header at cycle 4; header tag bits [63:62]=0 then 1; busy_o high cycles 1-3.
3. All 4 requesters send len=0 headers continuously -> grant order 0,1,2,3,0,...; each header tagged with its source index.
4. Req2 in BODY with cnt_r=2, req2 drops valid 2 cycles while req0 valid -> link_valid_o=0 for those cycles, grant_o stays 2, packet resumes, req0 never granted mid-packet.
5. link_ready_i toggles 1,0,1,0 during a len=2 packet -> exactly 3 transfers, no duplicated or lost flit, rr_ptr advances only after the last flit.
6. core_reset_n_i pulsed low mid-BODY (cnt_r=5) -> next cycle state IDLE, busy_o=0, rr_ptr=0. With BSG_LINK_ARB_PERF_CNT_EN, counters read 0 after reset and 1,0,0,0 after one len=0 req0 header.

Source files
------------

// File: rtl/bsg_link_core_arbiter.sv
// Round-robin, packet-locking arbiter sharing one link core-side transmit port among requesters.
// Define BSG_LINK_ARB_PERF_CNT_EN to add per-requester saturating flit counters (perf_flits_o).
module bsg_link_core_arbiter #(
    parameter int unsigned num_req_p   = 4,
    parameter int unsigned width_p     = 64,
    parameter int unsigned len_width_p = 4,
    localparam int unsigned lg_num_req_lp = $clog2(num_req_p)
) (
    input  logic                           core_clk_i,
    input  logic                           core_reset_n_i,
    input  logic [num_req_p*width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]           req_valid_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic [width_p-1:0]             link_data_o,
    output logic                           link_valid_o,
    input  logic                           link_ready_i,
    output logic [lg_num_req_lp-1:0]       grant_o,
    output logic                           busy_o
`ifdef BSG_LINK_ARB_PERF_CNT_EN
    ,
    output logic [num_req_p*32-1:0]        perf_flits_o
`endif
);

    typedef enum logic [0:0] {StIdle, StBody} state_e;

    localparam logic [lg_num_req_lp:0] NumReq = (lg_num_req_lp + 1)'(num_req_p);

    // (base + off) mod num_req_p; both operands are already below num_req_p.
    function automatic logic [lg_num_req_lp-1:0] wrap_add(
        input logic [lg_num_req_lp-1:0] base,
        input logic [lg_num_req_lp-1:0] off
    );
        logic [lg_num_req_lp:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end
        return sum[lg_num_req_lp-1:0];
    endfunction

    state_e                   state_q, state_d;
    logic [lg_num_req_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [lg_num_req_lp-1:0] grant_q, grant_d;
    logic [len_width_p-1:0]   cnt_q, cnt_d;

    logic [width_p-1:0]       req_flit [num_req_p];
    logic [lg_num_req_lp-1:0] idle_grant;
    logic [lg_num_req_lp-1:0] cand;
    logic                     idle_found;
    logic [lg_num_req_lp-1:0] grant;
    logic [num_req_p-1:0]     grant_oh;
    logic [width_p-1:0]       sel_flit;
    logic [width_p-1:0]       hdr_flit;
    logic [len_width_p-1:0]   hdr_len;
    logic                     xfer;

    for (genvar i = 0; i < num_req_p; i++) begin : g_flit
        assign req_flit[i] = req_data_i[i*width_p +: width_p];
    end

    // First valid requester at or after rr_ptr, wrapping; rr_ptr itself when nobody is valid.
    always_comb begin
        idle_found = 1'b0;
        idle_grant = rr_ptr_q;
        cand       = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            cand = wrap_add(rr_ptr_q, lg_num_req_lp'(k));
            if (!idle_found && req_valid_i[cand]) begin
                idle_found = 1'b1;
                idle_grant = cand;
            end
        end
    end

    assign grant    = (state_q == StBody) ? grant_q : idle_grant;
    assign grant_oh = num_req_p'(1) << grant;
    assign sel_flit = req_flit[grant];
    assign hdr_len  = sel_flit[len_width_p-1:0];

    always_comb begin
        hdr_flit = sel_flit;
        hdr_flit[width_p-1 -: lg_num_req_lp] = grant;
    end

    // Outputs are forced quiet while reset is asserted, even before the first reset edge.
    assign link_data_o  = (state_q == StIdle) ? hdr_flit : sel_flit;
    assign link_valid_o = core_reset_n_i ? req_valid_i[grant] : 1'b0;
    assign req_ready_o  = (core_reset_n_i && link_ready_i) ? grant_oh : '0;
    assign grant_o      = core_reset_n_i ? grant : '0;
    assign busy_o       = core_reset_n_i ? (state_q == StBody) : 1'b0;
    assign xfer         = link_valid_o & link_ready_i;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (hdr_len == '0) begin
                        rr_ptr_d = wrap_add(grant, lg_num_req_lp'(1));
                    end else begin
                        grant_d = grant;
                        cnt_d   = hdr_len;
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (xfer) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = wrap_add(grant_q, lg_num_req_lp'(1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge core_clk_i) begin
        if (!core_reset_n_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BSG_LINK_ARB_PERF_CNT_EN
    logic [num_req_p-1:0] xfer_oh;
    assign xfer_oh = xfer ? grant_oh : '0;

    for (genvar i = 0; i < num_req_p; i++) begin : g_perf
        logic [31:0] flits_q;
        always_ff @(posedge core_clk_i) begin
            if (!core_reset_n_i) begin
                flits_q <= '0;
            end else if (xfer_oh[i] && (flits_q != 32'hFFFF_FFFF)) begin
                flits_q <= flits_q + 32'd1;
            end
        end
        assign perf_flits_o[i*32 +: 32] = flits_q;
    end
`endif

endmodule
